calc_sched: RTL and testbench
=============================

Name: calc_sched

Overview:
Multi-lane job scheduler and the parametrised successor of the single trigger/done control path of the calc top level.
- Accepts host job requests (job id plus ROM program start address) into a FIFO.
- Dispatches each job to the lowest-index idle calc lane (one loader/alu/RAM engine per lane).
- Measures per-job run cycles and returns completion records through a valid/ready port.
- Sits between the host control registers and NUM_LANES calc engine instances.

Parameters:
NUM_LANES, 2, number of calc engines served (1..8)
ROM_DEPTH, 1024, program ROM depth; PC width AW = $clog2(ROM_DEPTH)
JOB_FIFO_DEPTH, 4, job queue entries (power of two, >=2)
ID_WIDTH, 4, job id width
CNT_WIDTH, 16, cycle counter width (saturating)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
job_valid  in  1  job request valid
job_ready  out  1  job queue not full
job_id  in  ID_WIDTH  job tag
job_pc  in  AW  program start address in ROM
lane_trigger  out  NUM_LANES  one-cycle start pulse per lane
lane_pc  out  NUM_LANES*AW  start address per lane, lane i at [i*AW +: AW]
lane_done  in  NUM_LANES  one-cycle finish pulse per lane
cpl_valid  out  1  completion record valid
cpl_ready  in  1  completion consumer ready
cpl_id  out  ID_WIDTH  id of the completed job
cpl_lane  out  LW = max(1,$clog2(NUM_LANES))  lane that ran the job
cpl_cycles  out  CNT_WIDTH  run cycles of the job
busy  out  1  any job queued, running or unreported
err_spurious  out  1  sticky: lane_done seen on a lane not in RUN

Behaviour:
- Reset (clock edge with reset_n=0) produces all of the following; reset mid-operation abandons in-flight jobs and no completions are issued for them:
  - job FIFO empty, all lanes IDLE, cycle counters 0, round-robin pointer 0
  - lane_trigger=0, lane_pc=0, cpl_valid=0, cpl_id/cpl_lane/cpl_cycles=0, err_spurious=0
  - job_ready=1, busy=0
- Job FIFO:
  - Push on job_valid&&job_ready.
  - job_ready = !full, registered-state based. There is no bypass when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle keep the count unchanged.
- Lane FSM, per lane: IDLE -> RUN -> DONE_WAIT -> IDLE.
  - Dispatch: FIFO non-empty and at least one IDLE lane. Pick the lowest-index IDLE lane i, pop the head, and register lane_pc[i]=pc and the lane's id. lane_trigger[i]=1 for exactly the next cycle and the lane enters RUN.
  - At most one dispatch per cycle.
  - A job pushed at edge k triggers at the earliest in the cycle after edge k+1.
  - lane_pc[i] is held stable from trigger until the lane returns to IDLE.
  - RUN: the counter clears to 0 at dispatch and increments by 1 each cycle in RUN, saturating at 2^CNT_WIDTH-1.
  - lane_done[i] sampled in RUN: latch the count+1 (saturating) and go to DONE_WAIT. If done arrives the cycle right after the trigger, cycles=1.
  - lane_done[i] in IDLE or DONE_WAIT: ignored, and err_spurious is set (sticky until reset).
- Completion register (single entry):
  - Loads when empty, or when cpl_valid&&cpl_ready in the same cycle.
  - Source: round-robin among DONE_WAIT lanes, starting from the lane after the last one served.
  - The loaded lane returns to IDLE in that cycle and is dispatchable on the next cycle.
  - cpl_* fields are stable while cpl_valid=1 and cpl_ready=0.
  - A lane blocked in DONE_WAIT back-pressures dispatch to that lane only.
- Simultaneous lane_done on several lanes: all latch, then report one per cycle in round-robin order.
- busy = FIFO non-empty | any lane != IDLE | cpl_valid.

Test Plan:
1. Reset, push id=3 pc=0x040, lane0 done 5 cycles after its trigger, cpl_ready=1 -> lane_trigger=01 once, lane_pc[0]=0x040, completion id=3 lane=0 cycles=5, then busy=0.
2. NUM_LANES=2, push 4 jobs ids 0..3 back-to-back, no lane_done -> triggers on lane0 then lane1 on consecutive cycles; 2 jobs stay queued; pushing 3 more leaves job_ready=0 after the FIFO reaches 4 entries.
3. Both lanes hold DONE_WAIT-pending done pulses in the same cycle, cpl_ready=0 for 3 cycles then 1 -> first record is held stable; records come out lane0 then lane1; the next queued job dispatches to lane0 in the cycle after its record loads.
4. CNT_WIDTH=4, lane runs 40 cycles -> cpl_cycles=15 (saturated).
5. lane_done[1] pulsed while lane1 is IDLE -> err_spurious=1 and stays 1; no completion issued.
6. Reset asserted while 2 jobs run and 1 is queued -> next cycle all outputs are at reset values and no stale completion appears afterwards.

Source files
------------

// File: rtl/calc_sched.sv
// calc_sched: multi-lane job scheduler for the calc engines.
//
// Host jobs (id + ROM start address) are queued in a small FIFO and dispatched
// one per cycle to the lowest-index idle lane. Each lane counts its run cycles
// until the engine reports done. Finished lanes are drained round-robin into a
// single-entry completion register with a valid/ready handshake.
//
// Ports:
//   clock, reset_n         system clock, synchronous active-low reset
//   job_valid/job_ready    job request handshake (ready = queue not full)
//   job_id, job_pc         job tag and program start address
//   lane_trigger           one-cycle start pulse per lane
//   lane_pc                start address per lane, lane i at [i*AW +: AW]
//   lane_done              one-cycle finish pulse per lane
//   cpl_valid/cpl_ready    completion record handshake
//   cpl_id, cpl_lane       id of the finished job and the lane that ran it
//   cpl_cycles             saturating run-cycle count of the finished job
//   busy                   any job queued, running or unreported
//   err_spurious           sticky: lane_done seen on a lane that was not running
module calc_sched #(
    parameter int NUM_LANES      = 2,
    parameter int ROM_DEPTH      = 1024,
    parameter int JOB_FIFO_DEPTH = 4,
    parameter int ID_WIDTH       = 4,
    parameter int CNT_WIDTH      = 16,
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [ID_WIDTH-1:0]     job_id,
    input  logic [AW-1:0]           job_pc,
    output logic [NUM_LANES-1:0]    lane_trigger,
    output logic [NUM_LANES*AW-1:0] lane_pc,
    input  logic [NUM_LANES-1:0]    lane_done,
    output logic                    cpl_valid,
    input  logic                    cpl_ready,
    output logic [ID_WIDTH-1:0]     cpl_id,
    output logic [LW-1:0]           cpl_lane,
    output logic [CNT_WIDTH-1:0]    cpl_cycles,
    output logic                    busy,
    output logic                    err_spurious
);
    localparam int PW = $clog2(JOB_FIFO_DEPTH);

    typedef enum logic [1:0] {
        LANE_IDLE,
        LANE_RUN,
        LANE_DONE_WAIT
    } lane_state_t;

    // Job FIFO
    logic [ID_WIDTH-1:0] fifo_id [JOB_FIFO_DEPTH];
    logic [AW-1:0]       fifo_pc [JOB_FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW:0]         fifo_count;
    logic                push;
    logic                pop;

    // Per-lane state
    lane_state_t          state_q   [NUM_LANES];
    lane_state_t          state_d   [NUM_LANES];
    logic [ID_WIDTH-1:0]  lane_id_q [NUM_LANES];
    logic [AW-1:0]        lane_pc_q [NUM_LANES];
    logic [CNT_WIDTH-1:0] cnt_q     [NUM_LANES];
    logic [NUM_LANES-1:0] trig_q;
    logic [NUM_LANES-1:0] run_mask;
    logic [NUM_LANES-1:0] active_mask;

    // Dispatch and completion selection
    logic          disp_en;
    logic [LW-1:0] disp_lane;
    logic          cpl_load;
    logic          sel_en;
    logic [LW-1:0] sel_lane;
    logic [LW-1:0] rr_ptr;
    logic [LW-1:0] rr_next;
    int unsigned   rr_idx;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign job_ready    = (fifo_count != (PW+1)'(JOB_FIFO_DEPTH));
    assign push         = job_valid && job_ready;
    assign pop          = disp_en;
    assign lane_trigger = trig_q;
    assign busy         = (fifo_count != '0) || (|active_mask) || cpl_valid;

    // Lowest-index idle lane takes the FIFO head.
    always_comb begin
        disp_en   = 1'b0;
        disp_lane = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!disp_en && (fifo_count != '0) && (state_q[i] == LANE_IDLE)) begin
                disp_en   = 1'b1;
                disp_lane = LW'(i);
            end
        end
    end

    // Round-robin pick among DONE_WAIT lanes, starting at rr_ptr.
    always_comb begin
        cpl_load = !cpl_valid || cpl_ready;
        sel_en   = 1'b0;
        sel_lane = '0;
        rr_idx   = 0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            rr_idx = 32'(rr_ptr) + k;
            if (rr_idx >= NUM_LANES) begin
                rr_idx = rr_idx - NUM_LANES;
            end
            if (!sel_en && (state_q[rr_idx] == LANE_DONE_WAIT)) begin
                sel_en   = 1'b1;
                sel_lane = LW'(rr_idx);
            end
        end
        rr_next = (sel_lane == LW'(NUM_LANES - 1)) ? '0 : sel_lane + 1'b1;
    end

    // Lane next-state logic.
    always_comb begin
        run_mask    = '0;
        active_mask = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            state_d[i]     = state_q[i];
            run_mask[i]    = (state_q[i] == LANE_RUN);
            active_mask[i] = (state_q[i] != LANE_IDLE);
            case (state_q[i])
                LANE_IDLE: begin
                    if (disp_en && (disp_lane == LW'(i))) begin
                        state_d[i] = LANE_RUN;
                    end
                end
                LANE_RUN: begin
                    if (lane_done[i]) begin
                        state_d[i] = LANE_DONE_WAIT;
                    end
                end
                LANE_DONE_WAIT: begin
                    if (cpl_load && sel_en && (sel_lane == LW'(i))) begin
                        state_d[i] = LANE_IDLE;
                    end
                end
                default: state_d[i] = LANE_IDLE;
            endcase
        end
    end

    always_comb begin
        lane_pc = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_pc[i*AW +: AW] = lane_pc_q[i];
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!reset_n) begin
                state_q[i] <= LANE_IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // FIFO storage needs no reset; only the pointers define its contents.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_id[wr_ptr] <= job_id;
            fifo_pc[wr_ptr] <= job_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            trig_q       <= '0;
            rr_ptr       <= '0;
            cpl_valid    <= 1'b0;
            cpl_id       <= '0;
            cpl_lane     <= '0;
            cpl_cycles   <= '0;
            err_spurious <= 1'b0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                lane_id_q[i] <= '0;
                lane_pc_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                trig_q[i] <= disp_en && (disp_lane == LW'(i));
                if (disp_en && (disp_lane == LW'(i))) begin
                    lane_id_q[i] <= fifo_id[rd_ptr];
                    lane_pc_q[i] <= fifo_pc[rd_ptr];
                    cnt_q[i]     <= '0;
                end else if ((state_q[i] == LANE_RUN) && (lane_done[i] || !trig_q[i])) begin
                    // The trigger cycle itself is not counted, so a done pulse
                    // one cycle after the trigger reports 1; the done cycle
                    // adds its own +1 as it latches.
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end
            end

            if (|(lane_done & ~run_mask)) begin
                err_spurious <= 1'b1;
            end

            if (cpl_load) begin
                if (sel_en) begin
                    cpl_valid  <= 1'b1;
                    cpl_id     <= lane_id_q[sel_lane];
                    cpl_lane   <= sel_lane;
                    cpl_cycles <= cnt_q[sel_lane];
                    rr_ptr     <= rr_next;
                end else begin
                    cpl_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: self-checking bench for calc_sched (2 lanes, 4-bit counters).
// Table-driven vectors, directed multi-cycle sequences and a randomized run
// compared against a queue-based reference model that derives run cycles
// from trigger/done timestamps.
module tb_calc_sched;
    localparam int NL    = 2;
    localparam int RD    = 1024;
    localparam int DEPTH = 4;
    localparam int IW    = 4;
    localparam int CW    = 4;
    localparam int AW    = 10;
    localparam int SAT   = (1 << CW) - 1;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           job_valid;
    logic           job_ready;
    logic [IW-1:0]  job_id;
    logic [AW-1:0]  job_pc;
    logic [NL-1:0]  lane_trigger;
    logic [NL*AW-1:0] lane_pc;
    logic [NL-1:0]  lane_done;
    logic           cpl_valid;
    logic           cpl_ready;
    logic [IW-1:0]  cpl_id;
    logic           cpl_lane;
    logic [CW-1:0]  cpl_cycles;
    logic           busy;
    logic           err_spurious;

    always #5 clock = ~clock;

    calc_sched #(
        .NUM_LANES(NL),
        .ROM_DEPTH(RD),
        .JOB_FIFO_DEPTH(DEPTH),
        .ID_WIDTH(IW),
        .CNT_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_id(job_id),
        .job_pc(job_pc),
        .lane_trigger(lane_trigger),
        .lane_pc(lane_pc),
        .lane_done(lane_done),
        .cpl_valid(cpl_valid),
        .cpl_ready(cpl_ready),
        .cpl_id(cpl_id),
        .cpl_lane(cpl_lane),
        .cpl_cycles(cpl_cycles),
        .busy(busy),
        .err_spurious(err_spurious)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        job_valid = 1'b0;
        job_id    = '0;
        job_pc    = '0;
        lane_done = '0;
        cpl_ready = 1'b1;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_ready"},   job_ready, 1);
        check({p, "_busy"},    busy, 0);
        check({p, "_trig"},    lane_trigger, 0);
        check({p, "_lanepc"},  lane_pc, 0);
        check({p, "_cvalid"},  cpl_valid, 0);
        check({p, "_cid"},     cpl_id, 0);
        check({p, "_clane"},   cpl_lane, 0);
        check({p, "_ccycles"}, cpl_cycles, 0);
        check({p, "_err"},     err_spurious, 0);
    endtask

    task automatic do_reset(input string p);
        reset_n = 1'b0;
        idle_inputs();
        tick();
        check_reset_vals(p);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic push_tick(input logic [IW-1:0] id, input logic [AW-1:0] pc);
        job_valid = 1'b1;
        job_id    = id;
        job_pc    = pc;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_cpl(input string name, input int budget);
        int n = 0;
        while (cpl_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, cpl_valid, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          jv;
        logic [IW-1:0] jid;
        logic [AW-1:0] jpc;
        logic [NL-1:0] done;
        logic          crdy;
        logic          e_ready;
        logic [NL-1:0] e_trig;
        logic          e_busy;
        logic          e_cv;
        logic [IW-1:0] e_id;
        logic [CW-1:0] e_cyc;
    } vec_t;

    // ---------------- reference model ----------------
    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] pc;
    } job_t;

    job_t          jq[$];
    int            m_st   [NL];   // 0 idle, 1 running, 2 finished awaiting report
    logic [IW-1:0] m_id   [NL];
    logic [AW-1:0] m_pc   [NL];
    int            m_tt   [NL];   // cycle in which the lane's trigger was high
    int            m_cyc  [NL];
    logic [NL-1:0] m_trig;
    logic          m_cv;
    logic [IW-1:0] m_cid;
    int            m_clane;
    int            m_ccyc;
    int            m_rr;
    logic          m_err;

    task automatic model_reset();
        jq.delete();
        for (int i = 0; i < NL; i++) begin
            m_st[i] = 0; m_id[i] = '0; m_pc[i] = '0; m_tt[i] = 0; m_cyc[i] = 0;
        end
        m_trig = '0; m_cv = 1'b0; m_cid = '0; m_clane = 0; m_ccyc = 0;
        m_rr = 0; m_err = 1'b0;
    endtask

    function automatic logic model_busy();
        logic b = (jq.size() != 0) || m_cv;
        for (int i = 0; i < NL; i++) if (m_st[i] != 0) b = 1'b1;
        return b;
    endfunction

    // Advance the model across the clock edge that ends cycle t.
    task automatic model_edge(input int t, input logic jv, input logic [IW-1:0] jid,
                              input logic [AW-1:0] jpc, input logic [NL-1:0] done,
                              input logic crdy);
        int   st0 [NL];
        logic can_push;
        logic found;
        int   j;
        st0      = m_st;
        can_push = jq.size() < DEPTH;
        m_trig   = '0;
        if (!m_cv || crdy) begin
            found = 1'b0;
            for (int k = 0; k < NL; k++) begin
                j = (m_rr + k) % NL;
                if (!found && st0[j] == 2) begin
                    found = 1'b1;
                    m_cv = 1'b1; m_cid = m_id[j]; m_clane = j; m_ccyc = m_cyc[j];
                    m_st[j] = 0;
                    m_rr = (j + 1) % NL;
                end
            end
            if (!found) m_cv = 1'b0;
        end
        for (int i = 0; i < NL; i++) begin
            if (done[i]) begin
                if (st0[i] == 1) begin
                    m_st[i]  = 2;
                    m_cyc[i] = (t - m_tt[i] > SAT) ? SAT : t - m_tt[i];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (jq.size() > 0) begin
            found = 1'b0;
            for (int i = 0; i < NL; i++) begin
                if (!found && st0[i] == 0) begin
                    found = 1'b1;
                    m_st[i] = 1; m_id[i] = jq[0].id; m_pc[i] = jq[0].pc;
                    m_tt[i] = t + 1;
                    m_trig[i] = 1'b1;
                    void'(jq.pop_front());
                end
            end
        end
        if (jv && can_push) jq.push_back('{jid, jpc});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [15];
        reset_n = 1'b0;
        idle_inputs();

        // ---- test 2 as a vector table (also covers completion + redispatch) ----
        tbl = '{
            '{1'b1, 4'd0, 10'h010, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0},
            '{1'b1, 4'd1, 10'h020, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b1, 4'd2, 10'h030, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b1, 4'd3, 10'h040, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b1, 4'd4, 10'h050, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b1, 4'd5, 10'h060, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b1, 4'd6, 10'h070, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b0, 4'd0, 10'h000, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b0, 4'd0, 10'h000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b0, 4'd0, 10'h000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 4'd0, 4'd5},
            '{1'b0, 4'd0, 10'h000, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b0, 4'd0, 10'h000, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b0, 4'd0, 10'h000, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0, 4'd0},
            '{1'b0, 4'd0, 10'h000, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd1, 4'd8},
            '{1'b0, 4'd0, 10'h000, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'd0, 4'd0}
        };
        do_reset("rst0");
        for (int r = 0; r < 15; r++) begin
            check($sformatf("vec%0d_ready", r), job_ready, tbl[r].e_ready);
            check($sformatf("vec%0d_trig", r), lane_trigger, tbl[r].e_trig);
            check($sformatf("vec%0d_busy", r), busy, tbl[r].e_busy);
            check($sformatf("vec%0d_cvalid", r), cpl_valid, tbl[r].e_cv);
            if (tbl[r].e_cv) begin
                check($sformatf("vec%0d_cid", r), cpl_id, tbl[r].e_id);
                check($sformatf("vec%0d_ccycles", r), cpl_cycles, tbl[r].e_cyc);
            end
            job_valid = tbl[r].jv;
            job_id    = tbl[r].jid;
            job_pc    = tbl[r].jpc;
            lane_done = tbl[r].done;
            cpl_ready = tbl[r].crdy;
            tick();
        end
        idle_inputs();

        // ---- test 1: single job, done 5 cycles after trigger ----
        do_reset("rst1");
        push_tick(4'd3, 10'h040);
        tick();
        check("t1_trig", lane_trigger, 2'b01);
        check("t1_pc0", lane_pc[AW-1:0], 10'h040);
        tick();
        check("t1_trig_once", lane_trigger, 2'b00);
        repeat (4) tick();
        check("t1_pc_held", lane_pc[AW-1:0], 10'h040);
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        wait_cpl("t1_cpl_arrives", 8);
        check("t1_cid", cpl_id, 3);
        check("t1_clane", cpl_lane, 0);
        check("t1_ccycles", cpl_cycles, 5);
        tick();
        check("t1_cvalid_clear", cpl_valid, 0);
        check("t1_busy_clear", busy, 0);

        // ---- test 3: simultaneous done, back-pressured completion ----
        do_reset("rst3");
        cpl_ready = 1'b0;
        push_tick(4'd5, 10'h100);
        push_tick(4'd6, 10'h104);
        push_tick(4'd7, 10'h108);
        check("t3_trig_l1", lane_trigger, 2'b10);
        repeat (2) tick();
        lane_done = 2'b11;
        tick();
        lane_done = 2'b00;
        tick();
        check("t3_first_valid", cpl_valid, 1);
        check("t3_first_id", cpl_id, 5);
        check("t3_first_lane", cpl_lane, 0);
        check("t3_first_cycles", cpl_cycles, 3);
        tick();
        check("t3_redispatch_l0", lane_trigger, 2'b01);
        check("t3_redispatch_pc", lane_pc[AW-1:0], 10'h108);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("t3_hold%0d_valid", c), cpl_valid, 1);
            check($sformatf("t3_hold%0d_id", c), cpl_id, 5);
            check($sformatf("t3_hold%0d_lane", c), cpl_lane, 0);
            check($sformatf("t3_hold%0d_cycles", c), cpl_cycles, 3);
            tick();
        end
        cpl_ready = 1'b1;
        tick();
        check("t3_second_valid", cpl_valid, 1);
        check("t3_second_id", cpl_id, 6);
        check("t3_second_lane", cpl_lane, 1);
        check("t3_second_cycles", cpl_cycles, 2);
        tick();
        check("t3_drained", cpl_valid, 0);
        check("t3_busy_l0_running", busy, 1);

        // ---- test 4: saturation ----
        do_reset("rst4");
        push_tick(4'd9, 10'h3ff);
        tick();
        check("t4_trig", lane_trigger, 2'b01);
        repeat (40) tick();
        lane_done = 2'b01;
        tick();
        lane_done = 2'b00;
        wait_cpl("t4_cpl_arrives", 8);
        check("t4_cid", cpl_id, 9);
        check("t4_saturated", cpl_cycles, SAT);

        // ---- test 5: spurious done ----
        do_reset("rst5");
        lane_done = 2'b10;
        tick();
        lane_done = 2'b00;
        check("t5_err_set", err_spurious, 1);
        repeat (3) tick();
        check("t5_err_sticky", err_spurious, 1);
        check("t5_no_cpl", cpl_valid, 0);
        check("t5_idle", busy, 0);

        // ---- test 6: reset mid-operation ----
        do_reset("rst6a");
        push_tick(4'd1, 10'h011);
        push_tick(4'd2, 10'h022);
        push_tick(4'd4, 10'h033);
        check("t6_l1_trig", lane_trigger, 2'b10);
        check("t6_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        check_reset_vals("t6_rst");
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("t6_after%0d_cvalid", c), cpl_valid, 0);
            check($sformatf("t6_after%0d_trig", c), lane_trigger, 0);
            check($sformatf("t6_after%0d_busy", c), busy, 0);
        end

        // ---- randomized run against the reference model ----
        do_reset("rst_rnd");
        model_reset();
        for (int t = 0; t < 1500; t++) begin
            logic          jv;
            logic [IW-1:0] jid;
            logic [AW-1:0] jpc;
            logic [NL-1:0] dn;
            logic          cr;
            check("rnd_trig", lane_trigger, m_trig);
            for (int i = 0; i < NL; i++) begin
                check($sformatf("rnd_lanepc%0d", i), lane_pc[i*AW +: AW], m_pc[i]);
            end
            check("rnd_ready", job_ready, jq.size() < DEPTH);
            check("rnd_busy", busy, model_busy());
            check("rnd_cvalid", cpl_valid, m_cv);
            check("rnd_err", err_spurious, m_err);
            if (m_cv) begin
                check("rnd_cid", cpl_id, m_cid);
                check("rnd_clane", cpl_lane, m_clane);
                check("rnd_ccycles", cpl_cycles, m_ccyc);
            end
            jv  = ($urandom_range(0, 1) == 0);
            jid = IW'($urandom);
            jpc = AW'($urandom_range(0, RD - 1));
            cr  = ($urandom_range(0, 3) != 0);
            dn  = '0;
            for (int i = 0; i < NL; i++) begin
                if (m_st[i] == 1 && t > m_tt[i] && $urandom_range(0, 5) == 0) dn[i] = 1'b1;
            end
            job_valid = jv; job_id = jid; job_pc = jpc; lane_done = dn; cpl_ready = cr;
            model_edge(t, jv, jid, jpc, dn, cr);
            tick();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
